// File: rtl/sorted_array_streamer.sv
// Captures a packed sorted array, checks it is non-decreasing, then
// streams its elements one per valid/ready transfer.
module sorted_array_streamer #(
    parameter int ARR_WIDTH = 4,
    parameter int ELEM_W    = 4,
    parameter int IDX_W     = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [ARR_WIDTH*ELEM_W-1:0] array_in,
    input  logic                        array_valid,
    output logic [ELEM_W-1:0]           elem_data,
    output logic [IDX_W-1:0]            elem_index,
    output logic                        elem_valid,
    output logic                        elem_last,
    input  logic                        elem_ready,
    output logic                        busy,
    output logic                        done,
    output logic                        order_ok,
    output logic                        order_err
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        STREAM,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARR_WIDTH - 1);
    localparam logic [IDX_W-1:0] CHK_END  =
        IDX_W'((ARR_WIDTH > 1) ? ARR_WIDTH - 2 : 0);

    state_t state, state_n;

    logic [ARR_WIDTH-1:0][ELEM_W-1:0] shadow, shadow_n;

    logic [IDX_W-1:0] idx, idx_n, idx_p1;
    logic err, err_n;
    logic ok_q, ok_n;
    logic bad_q, bad_n;
    logic vld_d;
    logic rise;
    logic is_last;

    assign rise    = array_valid & ~vld_d;
    assign idx_p1  = idx + 1'b1;
    assign is_last = (idx == LAST_IDX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            shadow <= '0;
            idx    <= '0;
            err    <= 1'b0;
            ok_q   <= 1'b0;
            bad_q  <= 1'b0;
            vld_d  <= 1'b0;
        end else begin
            state  <= state_n;
            shadow <= shadow_n;
            idx    <= idx_n;
            err    <= err_n;
            ok_q   <= ok_n;
            bad_q  <= bad_n;
            vld_d  <= array_valid;
        end
    end

    always_comb begin
        state_n  = state;
        shadow_n = shadow;
        idx_n    = idx;
        err_n    = err;
        ok_n     = ok_q;
        bad_n    = bad_q;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    shadow_n = array_in;
                    idx_n    = '0;
                    err_n    = 1'b0;
                    ok_n     = 1'b0;
                    bad_n    = 1'b0;
                    state_n  = (ARR_WIDTH > 1) ? CHECK : STREAM;
                end
            end
            CHECK: begin
                // Non-strict: equal neighbours are in order.
                if (shadow[idx] > shadow[idx_p1]) err_n = 1'b1;
                if (idx == CHK_END) begin
                    idx_n   = '0;
                    state_n = STREAM;
                end else begin
                    idx_n = idx_p1;
                end
            end
            STREAM: begin
                if (elem_ready) begin
                    if (is_last) begin
                        state_n = DONE;
                        ok_n    = ~err;
                        bad_n   = err;
                    end else begin
                        idx_n = idx_p1;
                    end
                end
            end
            DONE: begin
                idx_n   = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Element outputs are zeroed outside STREAM so idle outputs stay quiet.
    assign elem_valid = (state == STREAM);
    assign elem_data  = elem_valid ? shadow[idx] : '0;
    assign elem_index = elem_valid ? idx : '0;
    assign elem_last  = elem_valid & is_last;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign order_ok   = ok_q;
    assign order_err  = bad_q;

endmodule

// File: tb/tb_sorted_array_streamer.sv
// Scoreboard bench for sorted_array_streamer: stimulus pushes expected
// elements/flags, a negedge monitor pops and compares on each transfer.
module tb_sorted_array_streamer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] array_in = '0;
    logic        array_valid = 1'b0;
    logic [3:0]  elem_data;
    logic [1:0]  elem_index;
    logic        elem_valid;
    logic        elem_last;
    logic        elem_ready = 1'b1;
    logic        busy;
    logic        done;
    logic        order_ok;
    logic        order_err;

    sorted_array_streamer #(
        .ARR_WIDTH(4),
        .ELEM_W(4),
        .IDX_W(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .array_in(array_in),
        .array_valid(array_valid),
        .elem_data(elem_data),
        .elem_index(elem_index),
        .elem_valid(elem_valid),
        .elem_last(elem_last),
        .elem_ready(elem_ready),
        .busy(busy),
        .done(done),
        .order_ok(order_ok),
        .order_err(order_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int d;
        int i;
        bit l;
    } elem_t;

    elem_t exp_q[$];
    bit    flag_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int xfer_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: element i is nibble i; in order iff no descent.
    task automatic model_push(input logic [15:0] arr);
        int a[4];
        bit ok;
        elem_t e;
        for (int i = 0; i < 4; i++) a[i] = int'(arr[i*4 +: 4]);
        ok = 1'b1;
        for (int i = 0; i < 3; i++) if (a[i] > a[i+1]) ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e.d = a[i];
            e.i = i;
            e.l = (i == 3);
            exp_q.push_back(e);
        end
        flag_q.push_back(ok);
    endtask

    // Monitor
    bit       hold_v = 1'b0;
    int       hold_d, hold_i;
    bit       prev_last = 1'b0;

    always @(negedge clock) begin
        elem_t e;
        bit    ok;
        bit    now_last;
        if (!reset) begin
            hold_v    = 1'b0;
            prev_last = 1'b0;
        end else begin
            now_last = 1'b0;
            if (prev_last || done)
                chk("done_after_last", int'(done), int'(prev_last));
            if (done) begin
                if (flag_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    ok = flag_q.pop_front();
                    chk("order_ok", int'(order_ok), int'(ok));
                    chk("order_err", int'(order_err), int'(!ok));
                end
            end
            if (elem_valid) begin
                chk("flags_clear_in_stream", int'({order_ok, order_err}), 0);
                if (hold_v) begin
                    chk("stall_data", int'(elem_data), hold_d);
                    chk("stall_index", int'(elem_index), hold_i);
                end
            end else if (hold_v) begin
                chk("valid_dropped", 0, 1);
            end
            if (elem_valid && elem_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_elem", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("elem_data", int'(elem_data), e.d);
                    chk("elem_index", int'(elem_index), e.i);
                    chk("elem_last", int'(elem_last), int'(e.l));
                end
                now_last = elem_last;
            end
            hold_v    = elem_valid && !elem_ready;
            hold_d    = int'(elem_data);
            hold_i    = int'(elem_index);
            prev_last = now_last;
        end
    end

    // rmode: 0 ready=1, 1 random ready, 2 fixed stall pattern
    task automatic run_array(input logic [15:0] arr, input int rmode,
                             input bit glitch);
        bit fin = 1'b0;
        bit g = 1'b0;
        int pi = 0;
        bit pat[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        @(posedge clock); #1;
        array_in    = arr;
        array_valid = 1'b1;
        model_push(arr);
        @(posedge clock); #1;
        array_valid = 1'b0;
        array_in    = 16'($urandom);
        for (int c = 0; c < 100 && !fin; c++) begin
            if (glitch && elem_valid && !g) begin
                array_in    = 16'hFFFF;
                array_valid = 1'b1;
                g = 1'b1;
            end else begin
                array_valid = 1'b0;
            end
            if (rmode == 1) elem_ready = 1'($urandom_range(0, 1));
            else if (rmode == 2 && elem_valid && pi < 8) elem_ready = pat[pi++];
            else elem_ready = 1'b1;
            @(posedge clock); #1;
            if (done) fin = 1'b1;
        end
        if (!fin) chk("done_timeout", 0, 1);
        array_valid = 1'b0;
        elem_ready  = 1'b1;
    endtask

    initial begin
        int x0;
        int vals[$];
        logic [15:0] arr;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_valid", int'(elem_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_flags", int'({order_ok, order_err}), 0);
        chk("rst_data", int'({elem_data, elem_index, elem_last}), 0);
        @(posedge clock); #1;
        reset = 1'b1;

        run_array(16'h9531, 0, 1'b0);
        run_array(16'h1953, 0, 1'b0);
        run_array(16'h7777, 0, 1'b0);
        x0 = xfer_cnt;
        run_array(16'h9531, 2, 1'b0);
        chk("pattern_xfers", xfer_cnt - x0, 4);
        x0 = xfer_cnt;
        run_array(16'h9531, 0, 1'b1);
        chk("glitch_xfers", xfer_cnt - x0, 4);
        run_array(16'h4321, 0, 1'b0);

        // Reset in the middle of a stream
        @(posedge clock); #1;
        x0 = xfer_cnt;
        array_in    = 16'h9531;
        array_valid = 1'b1;
        model_push(16'h9531);
        @(posedge clock); #1;
        array_valid = 1'b0;
        for (int c = 0; c < 50 && (xfer_cnt - x0) < 2; c++) begin
            @(posedge clock); #1;
        end
        chk("pre_reset_xfers", xfer_cnt - x0, 2);
        reset = 1'b0;
        exp_q.delete();
        flag_q.delete();
        #1;
        chk("midrst_valid", int'(elem_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_flags", int'({order_ok, order_err}), 0);
        chk("midrst_data", int'({elem_data, elem_index, elem_last}), 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        run_array(16'h8642, 0, 1'b0);

        for (int t = 0; t < 12; t++) begin
            vals.delete();
            for (int i = 0; i < 4; i++) vals.push_back($urandom_range(0, 15));
            if (t % 2 == 0) vals.sort();
            for (int i = 0; i < 4; i++) arr[i*4 +: 4] = 4'(vals[i]);
            run_array(arr, 1, 1'(t % 3 == 0));
        end

        repeat (5) @(posedge clock);
        #1;
        chk("elem_queue_empty", exp_q.size(), 0);
        chk("flag_queue_empty", flag_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
